mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the instruction-fetch stage (IF) and the data-access stage (DM) of the five-stage core.
- Sequences each access as a bus transaction and returns the read data and an acknowledge to the stage that issued it.
- Drives a stall request to the pipeline controller while any access is outstanding.
- Gives DM fixed priority, with a starvation limit that guarantees IF forward progress.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 4, number of consecutive DM grants made while IF is waiting before IF is forced to win the next arbitration.
- TIMEOUT, 16, maximum GRANT cycles without bus_ack_i before the transaction is aborted.

Ports:
- clk in 1: clock. All state updates on the rising edge.
- rst in 1: reset, asynchronous, active-high.
- if_req_i in 1: IF fetch request, level.
- if_addr_i in AW: fetch address.
- if_data_o out DW: fetched word.
- if_ack_o out 1: fetch done, one-cycle pulse.
- if_err_o out 1: fetch timed out, pulses with if_ack_o.
- dm_req_i in 1: DM request, level.
- dm_we_i in 1: 1 = write, 0 = read.
- dm_sel_i in DW/8: byte enables.
- dm_addr_i in AW: data address.
- dm_wdata_i in DW: write data.
- dm_rdata_o out DW: read data.
- dm_ack_o out 1: DM access done, one-cycle pulse.
- dm_err_o out 1: DM access timed out, pulses with dm_ack_o.
- bus_ce_o out 1: memory chip enable.
- bus_we_o out 1: memory write enable.
- bus_sel_o out DW/8: memory byte enables.
- bus_addr_o out AW: memory address.
- bus_wdata_o out DW: memory write data.
- bus_rdata_i in DW: memory read data.
- bus_ack_i in 1: memory transaction complete.
- stall_req_o out 1: stall request to the pipeline controller.

Behaviour:
- Reset (async, rst=1): state IDLE; starve count 0; timeout count 0; every output 0 (stall_req_o is 0 because the requests are ignored during reset). The bus is released immediately, even mid-transaction. On rst release the arbiter resumes in IDLE.
- State machine has three states: IDLE, GRANT_IF, GRANT_DM.
- IDLE, arbitration at each edge:
  - If dm_req_i=1 and (if_req_i=0 or starve count < STARVE_MAX): go to GRANT_DM.
  - Else if if_req_i=1: go to GRANT_IF.
  - Else stay in IDLE.
- Grant entry: on the entering edge, register the bus outputs.
  - GRANT_IF: bus_addr_o=if_addr_i, bus_we_o=0, bus_sel_o=all ones, bus_wdata_o=0.
  - GRANT_DM: bus_addr_o, bus_we_o, bus_sel_o and bus_wdata_o take the dm_* inputs.
  - bus_ce_o=1 for the whole GRANT state.
  - Bus outputs hold stable until exit; request inputs are ignored while granted.
- Starve count update at DM grant entry:
  - DM granted while if_req_i=1: count increments, saturating at STARVE_MAX.
  - DM granted while if_req_i=0: count is 0.
  - IF granted: count is 0.
- GRANT exit on bus_ack_i=1 sampled at an edge:
  - Registered at that same edge: the requester's ack=1; its data output = bus_rdata_i (0 for DM writes); bus_ce_o=0; go to IDLE.
  - The ack is high for exactly the one IDLE cycle that follows.
  - The *_data_o / dm_rdata_o registers hold their value until the next ack to the same requester.
- Timeout:
  - The timeout count is 0 at grant entry and increments each GRANT cycle without bus_ack_i.
  - When it reaches TIMEOUT-1 with bus_ack_i still 0: at that edge, ack=1 and err=1 to the requester, data output 0, bus_ce_o=0, go to IDLE.
  - bus_ack_i arriving in the same cycle as the timeout limit wins: normal completion, err=0.
- Latency and throughput: with memory ack in the first GRANT cycle, the request-to-ack latency is 2 cycles. Peak throughput is one access per 2 cycles; the IDLE cycle between grants is mandatory.
- Back-to-back: a requester that keeps req=1 in its ack cycle is treated as issuing a new request and is re-arbitrated at the next edge.
- stall_req_o is combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
- bus_ack_i sampled in IDLE is ignored.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; state IDLE after release.
- Single IF: if_req_i=1, if_addr_i=0x0000_0004; memory acks in the first GRANT cycle with 0x3401_1100 -> bus_addr_o=0x4, bus_we_o=0, bus_sel_o=0xF; if_ack_o pulses 2 cycles after the request with if_data_o=0x3401_1100; stall_req_o=1 for exactly 2 cycles.
- Simultaneous requests: if_req_i and dm_req_i (write, addr 0x100, data 0xDEAD_BEEF, sel 0x3) rise together -> DM transaction first with bus_we_o=1, bus_sel_o=0x3; then one IDLE cycle; then IF transaction; dm_ack_o precedes if_ack_o by 2 cycles.
- Starvation (STARVE_MAX=2, both requests held high, immediate acks) -> grant order DM, DM, IF, DM, DM, IF.
- Timeout (TIMEOUT=4, bus_ack_i held 0, DM read) -> bus_ce_o high for 4 cycles; then dm_ack_o=1, dm_err_o=1, dm_rdata_o=0; the next transaction proceeds normally with err=0.
- Reset mid-transaction: rst during GRANT_IF, before ack -> bus_ce_o drops immediately and no ack is issued; after release with if_req_i=1, a fresh GRANT_IF completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory bus between the IF and DM stages; DM has priority, IF is protected from starvation.
// Latency: request to ack is 2 cycles when memory acks in the first grant cycle; an IDLE cycle always separates grants.
// Backpressure: requests are levels held until acked; stall_req_o holds the pipeline while a request is pending; a silent memory is aborted after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic            clk,
  input  logic            rst,
  // instruction fetch port
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic [DW-1:0]   if_data_o,
  output logic            if_ack_o,
  output logic            if_err_o,
  // data access port
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [DW/8-1:0] dm_sel_i,
  input  logic [AW-1:0]   dm_addr_i,
  input  logic [DW-1:0]   dm_wdata_i,
  output logic [DW-1:0]   dm_rdata_o,
  output logic            dm_ack_o,
  output logic            dm_err_o,
  // shared memory bus
  output logic            bus_ce_o,
  output logic            bus_we_o,
  output logic [DW/8-1:0] bus_sel_o,
  output logic [AW-1:0]   bus_addr_o,
  output logic [DW-1:0]   bus_wdata_o,
  input  logic [DW-1:0]   bus_rdata_i,
  input  logic            bus_ack_i,
  // pipeline control
  output logic            stall_req_o
);

  // Counter widths: the starve counter must hold STARVE_MAX itself, the
  // timeout counter only needs to reach TIMEOUT-1.
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_DM = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;

  // Decoded events for the datapath registers.
  logic enter_if;
  logic enter_dm;
  logic finish;   // memory acked the current grant
  logic abort;    // grant ran out of time without a memory ack

  // State and counter registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      tmo_cnt    <= tmo_nxt;
    end
  end

  // Arbitration, grant completion and timeout decisions.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    tmo_nxt    = tmo_cnt;
    enter_if   = 1'b0;
    enter_dm   = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;

    case (state)
      IDLE: begin
        // Timeout count always starts from zero at grant entry.
        tmo_nxt = '0;
        if (dm_req_i && (!if_req_i || (starve_cnt < STARVE_LIM))) begin
          state_nxt = GRANT_DM;
          enter_dm  = 1'b1;
          // Only DM grants that pass over a waiting IF count toward starvation.
          if (!if_req_i) begin
            starve_nxt = '0;
          end else if (starve_cnt != STARVE_LIM) begin
            starve_nxt = starve_cnt + 1'b1;
          end
        end else if (if_req_i) begin
          state_nxt  = GRANT_IF;
          enter_if   = 1'b1;
          starve_nxt = '0;
        end
      end

      GRANT_IF, GRANT_DM: begin
        // A memory ack in the limit cycle still counts as a clean completion.
        if (bus_ack_i) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered bus drive, acks, error flags and returned data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_ce_o    <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      if_err_o    <= 1'b0;
      if_data_o   <= '0;
      dm_ack_o    <= 1'b0;
      dm_err_o    <= 1'b0;
      dm_rdata_o  <= '0;
    end else begin
      // Acks and errors are single-cycle pulses.
      if_ack_o <= 1'b0;
      if_err_o <= 1'b0;
      dm_ack_o <= 1'b0;
      dm_err_o <= 1'b0;

      if (enter_if) begin
        bus_ce_o    <= 1'b1;
        bus_we_o    <= 1'b0;
        bus_sel_o   <= '1;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= '0;
      end else if (enter_dm) begin
        bus_ce_o    <= 1'b1;
        bus_we_o    <= dm_we_i;
        bus_sel_o   <= dm_sel_i;
        bus_addr_o  <= dm_addr_i;
        bus_wdata_o <= dm_wdata_i;
      end

      if (finish || abort) begin
        bus_ce_o <= 1'b0;
        if (state == GRANT_IF) begin
          if_ack_o  <= 1'b1;
          if_err_o  <= abort;
          if_data_o <= abort ? '0 : bus_rdata_i;
        end else begin
          dm_ack_o   <= 1'b1;
          dm_err_o   <= abort;
          // Writes return no data.
          dm_rdata_o <= (abort || bus_we_o) ? '0 : bus_rdata_i;
        end
      end
    end
  end

  // Stall while any request is pending and not being acked this cycle;
  // requests are not honoured during reset, so the stall is masked too.
  always_comb begin
    stall_req_o = !rst && ((if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            if_req_i;
  logic [AW-1:0]   if_addr_i;
  logic [DW-1:0]   if_data_o;
  logic            if_ack_o;
  logic            if_err_o;
  logic            dm_req_i;
  logic            dm_we_i;
  logic [DW/8-1:0] dm_sel_i;
  logic [AW-1:0]   dm_addr_i;
  logic [DW-1:0]   dm_wdata_i;
  logic [DW-1:0]   dm_rdata_o;
  logic            dm_ack_o;
  logic            dm_err_o;
  logic            bus_ce_o;
  logic            bus_we_o;
  logic [DW/8-1:0] bus_sel_o;
  logic [AW-1:0]   bus_addr_o;
  logic [DW-1:0]   bus_wdata_o;
  logic [DW-1:0]   bus_rdata_i;
  logic            bus_ack_i;
  logic            stall_req_o;

  int errors = 0;
  int checks = 0;

  // Memory model knobs.
  bit mem_ack_en;
  int mem_delay;
  int ce_cyc;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_if[$];
  exp_t exp_dm[$];

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(2), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .if_ack_o(if_ack_o), .if_err_o(if_err_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o),
    .dm_ack_o(dm_ack_o), .dm_err_o(dm_err_o),
    .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stall_req_o(stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return a ^ 32'h3401_1104;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_if(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    exp_if.push_back(x);
  endtask

  task automatic push_dm(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    exp_dm.push_back(x);
  endtask

  // Waits (bounded) for an ack pulse; reports which requester got it.
  task automatic wait_ack(output bit who_if);
    bit got;
    got    = 1'b0;
    who_if = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if_ack_o || dm_ack_o) begin
        got    = 1'b1;
        who_if = if_ack_o;
        break;
      end
      tick();
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL ack_wait observed=no_ack expected=ack");
    end
  endtask

  // Memory responder: acks mem_delay cycles into a grant when enabled.
  initial begin
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
    ce_cyc      = 0;
    forever begin
      @(posedge clk);
      #2;
      if (bus_ce_o) begin
        bus_ack_i   = mem_ack_en && (ce_cyc == mem_delay);
        bus_rdata_i = bus_ack_i ? rd_val(bus_addr_o) : '0;
        ce_cyc++;
      end else begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        ce_cyc      = 0;
      end
    end
  end

  // Scoreboard: every ack pulse pops and compares the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && if_ack_o) begin
        checks++;
        assert (exp_if.size() != 0) else begin
          errors++;
          $error("FAIL if_ack_unexpected observed=ack expected=none");
        end
        if (exp_if.size() != 0) begin
          e = exp_if.pop_front();
          chk("if_data", if_data_o, e.data);
          chk("if_err", 32'(if_err_o), 32'(e.err));
        end
      end
      if (!rst && dm_ack_o) begin
        checks++;
        assert (exp_dm.size() != 0) else begin
          errors++;
          $error("FAIL dm_ack_unexpected observed=ack expected=none");
        end
        if (exp_dm.size() != 0) begin
          e = exp_dm.pop_front();
          chk("dm_rdata", dm_rdata_o, e.data);
          chk("dm_err", 32'(dm_err_o), 32'(e.err));
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          who_if;
    int          n;
    logic [5:0]  order_pat;

    rst        = 1'b1;
    if_req_i   = 1'b0;
    if_addr_i  = '0;
    dm_req_i   = 1'b0;
    dm_we_i    = 1'b0;
    dm_sel_i   = '0;
    dm_addr_i  = '0;
    dm_wdata_i = '0;
    mem_ack_en = 1'b1;
    mem_delay  = 0;

    // Reset: requests are ignored and all outputs stay low.
    tick();
    if_req_i = 1'b1;
    dm_req_i = 1'b1;
    tick();
    tick();
    chk("rst_ce", 32'(bus_ce_o), 32'd0);
    chk("rst_stall", 32'(stall_req_o), 32'd0);
    chk("rst_acks", 32'({if_ack_o, dm_ack_o, if_err_o, dm_err_o}), 32'd0);
    chk("rst_bus_addr", bus_addr_o, 32'd0);
    chk("rst_data", if_data_o | dm_rdata_o, 32'd0);
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    rst      = 1'b0;
    tick();
    chk("post_rst_idle_ce", 32'(bus_ce_o), 32'd0);

    // Single IF fetch with immediate memory ack.
    if_addr_i = 32'h0000_0004;
    if_req_i  = 1'b1;
    push_if(32'h3401_1100, 1'b0);
    #1;
    chk("if1_stall_c0", 32'(stall_req_o), 32'd1);
    tick();
    chk("if1_ce", 32'(bus_ce_o), 32'd1);
    chk("if1_addr", bus_addr_o, 32'h4);
    chk("if1_we", 32'(bus_we_o), 32'd0);
    chk("if1_sel", 32'(bus_sel_o), 32'hF);
    chk("if1_stall_c1", 32'(stall_req_o), 32'd1);
    chk("if1_ack_early", 32'(if_ack_o), 32'd0);
    tick();
    chk("if1_ack", 32'(if_ack_o), 32'd1);
    chk("if1_data", if_data_o, 32'h3401_1100);
    chk("if1_stall_ack", 32'(stall_req_o), 32'd0);
    if_req_i = 1'b0;
    tick();
    chk("if1_ack_pulse", 32'(if_ack_o), 32'd0);
    chk("if1_ce_off", 32'(bus_ce_o), 32'd0);
    chk("if1_data_hold", if_data_o, 32'h3401_1100);

    // Simultaneous requests: DM write wins, then IF after one IDLE cycle.
    if_addr_i  = 32'h0000_0008;
    if_req_i   = 1'b1;
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_addr_i  = 32'h0000_0100;
    dm_wdata_i = 32'hDEAD_BEEF;
    dm_sel_i   = 4'h3;
    push_dm(32'h0, 1'b0);
    push_if(rd_val(32'h8), 1'b0);
    tick();
    chk("sim_dm_ce", 32'(bus_ce_o), 32'd1);
    chk("sim_dm_we", 32'(bus_we_o), 32'd1);
    chk("sim_dm_sel", 32'(bus_sel_o), 32'h3);
    chk("sim_dm_addr", bus_addr_o, 32'h100);
    chk("sim_dm_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    tick();
    chk("sim_dm_ack", 32'(dm_ack_o), 32'd1);
    chk("sim_idle_ce", 32'(bus_ce_o), 32'd0);
    chk("sim_stall_if_wait", 32'(stall_req_o), 32'd1);
    dm_req_i = 1'b0;
    tick();
    chk("sim_if_ce", 32'(bus_ce_o), 32'd1);
    chk("sim_if_addr", bus_addr_o, 32'h8);
    chk("sim_if_we", 32'(bus_we_o), 32'd0);
    tick();
    chk("sim_if_ack", 32'(if_ack_o), 32'd1);
    if_req_i = 1'b0;
    tick();

    // Starvation limit 2: both held high gives DM, DM, IF, DM, DM, IF.
    order_pat = 6'b100100;
    if_addr_i = 32'h0000_000C;
    dm_we_i   = 1'b0;
    dm_sel_i  = 4'hF;
    dm_addr_i = 32'h0000_0200;
    for (int k = 0; k < 4; k++) push_dm(rd_val(32'h200), 1'b0);
    for (int k = 0; k < 2; k++) push_if(rd_val(32'hC), 1'b0);
    if_req_i = 1'b1;
    dm_req_i = 1'b1;
    tick();
    for (int g = 0; g < 6; g++) begin
      wait_ack(who_if);
      chk($sformatf("starve_order_%0d", g), 32'(who_if), 32'(order_pat[g]));
      if (g == 5) begin
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
      end
      tick();
    end

    // Timeout: silent memory, DM read aborted after 4 grant cycles.
    mem_ack_en = 1'b0;
    dm_addr_i  = 32'h0000_0300;
    dm_req_i   = 1'b1;
    push_dm(32'h0, 1'b1);
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (dm_ack_o) break;
      if (bus_ce_o) n++;
      tick();
    end
    chk("tmo_ce_cycles", 32'(n), 32'd4);
    chk("tmo_ack", 32'(dm_ack_o), 32'd1);
    chk("tmo_err", 32'(dm_err_o), 32'd1);
    chk("tmo_rdata", dm_rdata_o, 32'd0);
    dm_req_i = 1'b0;
    tick();

    // Memory ack in the limit cycle still completes cleanly.
    mem_ack_en = 1'b1;
    mem_delay  = 3;
    dm_addr_i  = 32'h0000_0304;
    dm_req_i   = 1'b1;
    push_dm(rd_val(32'h304), 1'b0);
    tick();
    wait_ack(who_if);
    chk("tmo_edge_who", 32'(who_if), 32'd0);
    chk("tmo_edge_err", 32'(dm_err_o), 32'd0);
    dm_req_i = 1'b0;
    tick();

    // Reset in the middle of an IF grant: bus drops at once, no ack.
    mem_ack_en = 1'b0;
    mem_delay  = 0;
    if_addr_i  = 32'h0000_0010;
    if_req_i   = 1'b1;
    tick();
    chk("mid_ce_before", 32'(bus_ce_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_ce_async", 32'(bus_ce_o), 32'd0);
    chk("mid_stall_async", 32'(stall_req_o), 32'd0);
    chk("mid_if_data_async", if_data_o, 32'd0);
    chk("mid_addr_async", bus_addr_o, 32'd0);
    tick();
    tick();
    chk("mid_no_ack", 32'(if_ack_o), 32'd0);
    mem_ack_en = 1'b1;
    push_if(rd_val(32'h10), 1'b0);
    rst = 1'b0;
    tick();
    chk("mid_regrant_ce", 32'(bus_ce_o), 32'd1);
    chk("mid_regrant_addr", bus_addr_o, 32'h10);
    wait_ack(who_if);
    chk("mid_regrant_who", 32'(who_if), 32'd1);
    if_req_i = 1'b0;
    tick();
    tick();

    chk("sb_if_drained", 32'(exp_if.size()), 32'd0);
    chk("sb_dm_drained", 32'(exp_dm.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
